// File: rtl/rf_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter_pkg
// Description : Shared widths, register-zero constant and arbiter state codes
//               for the register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wport_arbiter_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int MAX_WAIT_DEF = 4;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } arb_state_t;

    // Counter must be able to hold MAX_WAIT itself (saturation value).
    function automatic int wait_cnt_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wport_arbiter_mux2.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter_mux2
// Description : Two-input mux used for the destination and write-data paths;
//               s = 1 selects the r1 (mult/div) input.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter_mux2 #(
    parameter int WIDTH = 5
) (
    input  logic             s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = s ? b : a;

endmodule
`default_nettype wire

// File: rtl/rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wport_arbiter
// Description : Shares the register-file write port between the pipeline
//               writeback (r0, fixed priority) and the mult/div unit (r1,
//               aging-protected). Winning write is registered one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_dest,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_dest,
    input  logic [DATA_W-1:0] r1_data,
    output logic              wsel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wn,
    output logic [DATA_W-1:0] rf_d,
    output logic              starved
);

    localparam int                c_cnt_w     = wait_cnt_w(MAX_WAIT);
    localparam logic [c_cnt_w-1:0] c_wait_max  = c_cnt_w'(MAX_WAIT);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(MAX_WAIT - 1);
    localparam logic [ADDR_W-1:0]  c_zero_reg  = ADDR_W'(ZERO_REG);

    arb_state_t         r_state;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_wsel;
    logic               r_rf_we;
    logic [ADDR_W-1:0]  r_rf_wn;
    logic [DATA_W-1:0]  r_rf_d;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_grant;
    logic               w_r1_loses;
    logic [ADDR_W-1:0]  w_dest;
    logic [DATA_W-1:0]  w_data;

    // Grants depend only on the valids and the registered state.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == STARVED) begin
            w_grant1 = r1_valid;
            w_grant0 = r0_valid && !r1_valid;
        end else begin
            w_grant0 = r0_valid;
            w_grant1 = r1_valid && !r0_valid;
        end
    end

    assign w_grant    = w_grant0 || w_grant1;
    assign w_r1_loses = r1_valid && !w_grant1;

    rf_wport_arbiter_mux2 #(.WIDTH(ADDR_W)) u_mux2x5 (
        .s (w_grant1),
        .a (r0_dest),
        .b (r1_dest),
        .y (w_dest)
    );

    rf_wport_arbiter_mux2 #(.WIDTH(DATA_W)) u_mux2x32 (
        .s (w_grant1),
        .a (r0_data),
        .b (r1_data),
        .y (w_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= NORMAL;
            r_wait_cnt <= '0;
            r_wsel     <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_wn    <= '0;
            r_rf_d     <= '0;
        end else begin
            // Register zero is accepted but never written.
            if (w_grant) begin
                r_wsel  <= w_grant1;
                r_rf_we <= (w_dest != c_zero_reg);
                r_rf_wn <= w_dest;
                r_rf_d  <= w_data;
            end else begin
                r_rf_we <= 1'b0;
            end

            if (!r1_valid || w_grant1) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_wait_max) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (r_state == NORMAL) begin
                if (w_r1_loses && (r_wait_cnt == c_wait_last)) begin
                    r_state <= STARVED;
                end
            end else begin
                if (w_grant1 || !r1_valid) begin
                    r_state <= NORMAL;
                end
            end
        end
    end

    assign r0_ready = w_grant0;
    assign r1_ready = w_grant1;
    assign wsel     = r_wsel;
    assign rf_we    = r_rf_we;
    assign rf_wn    = r_rf_wn;
    assign rf_d     = r_rf_d;
    assign starved  = (r_state == STARVED);

endmodule
`default_nettype wire
